// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 add/sub unit between
// two requesters. A tag shift register follows each issued operation
// through the unit so its result can be steered back to the owner.
module fp_addsub_arbiter #(
    parameter int LAT   = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             fu_valid,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic             fu_op,
    input  logic             fu_res_valid,
    input  logic [WIDTH-1:0] fu_result,
    output logic             busy,
    output logic             err_mismatch
);

    // Priority pointer: 0 favours requester 0 when both are valid.
    logic           ptr;
    logic           grant0;
    logic           grant1;
    // Owner id of the operation currently presented on fu_*.
    logic           issue_id;
    // Tag pipeline behind the issue register; index LAT-1 is the tail,
    // aligned with the cycle the unit returns the matching result.
    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_id;
    logic           tail_vld;
    logic           tail_id;

    // Grant decision: single valid wins outright, ties go to the pointer.
    always_comb begin
        grant0 = en & req0_valid & (~req1_valid | ~ptr);
        grant1 = en & req1_valid & (~req0_valid | ptr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign tail_vld   = tag_vld[LAT-1];
    assign tail_id    = tag_id[LAT-1];

    // Pointer flips to the other requester after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Issue register: operands captured on handshake, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_valid <= 1'b0;
            fu_a     <= '0;
            fu_b     <= '0;
            fu_op    <= 1'b0;
            issue_id <= 1'b0;
        end else begin
            fu_valid <= grant0 | grant1;
            if (grant0) begin
                fu_a     <= req0_a;
                fu_b     <= req0_b;
                fu_op    <= req0_op;
                issue_id <= 1'b0;
            end else if (grant1) begin
                fu_a     <= req1_a;
                fu_b     <= req1_b;
                fu_op    <= req1_op;
                issue_id <= 1'b1;
            end
        end
    end

    // Tag shift register advancing every cycle alongside the unit pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= fu_valid;
            tag_id[0]  <= issue_id;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Response steering; a tail/result disagreement produces no response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            rsp0_valid <= tail_vld & fu_res_valid & ~tail_id;
            rsp1_valid <= tail_vld & fu_res_valid & tail_id;
            if (tail_vld && fu_res_valid && !tail_id) begin
                rsp0_result <= fu_result;
            end
            if (tail_vld && fu_res_valid && tail_id) begin
                rsp1_result <= fu_result;
            end
        end
    end

    // Sticky protocol error: unit strobe and tag tail must always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch <= 1'b0;
        end else if (tail_vld != fu_res_valid) begin
            err_mismatch <= 1'b1;
        end
    end

    assign busy = fu_valid | (|tag_vld) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: a behavioural shared unit with fixed latency,
// directed stimulus, and a per-requester scoreboard of expected responses.
module tb_fp_addsub_arbiter;

    localparam int LAT   = 3;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             req0_valid, req0_ready, req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             fu_valid, fu_op;
    logic [WIDTH-1:0] fu_a, fu_b;
    logic             fu_res_valid;
    logic [WIDTH-1:0] fu_result;
    logic             busy, err_mismatch;
    logic             inject;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gcyc;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];

    fp_addsub_arbiter #(.LAT(LAT), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_res_valid(fu_res_valid), .fu_result(fu_result),
        .busy(busy), .err_mismatch(err_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Known FP32 sums/differences; other operand pairs get an arbitrary
    // but deterministic value so steering is still observable.
    function automatic logic [WIDTH-1:0] fp_model(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic op);
        case ({a, b, op})
            {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
            {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000;
            {32'h40000000, 32'h40000000, 1'b0}: return 32'h40800000;
            {32'h40800000, 32'h3F800000, 1'b1}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000, 1'b0}: return 32'h40000000;
            default: return a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
        endcase
    endfunction

    // Shared unit model: fixed LAT-cycle pipeline, reset with the arbiter.
    logic [LAT-1:0]   uv;
    logic [WIDTH-1:0] ur [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uv <= '0;
            for (int i = 0; i < LAT; i++) ur[i] <= '0;
        end else begin
            uv[0] <= fu_valid;
            ur[0] <= fp_model(fu_a, fu_b, fu_op);
            for (int i = 1; i < LAT; i++) begin
                uv[i] <= uv[i-1];
                ur[i] <= ur[i-1];
            end
        end
    end
    assign fu_res_valid = uv[LAT-1] | inject;
    assign fu_result    = ur[LAT-1];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: push on handshake, pop and compare on response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready)
                exp0.push_back('{cyc: cyc, res: fp_model(req0_a, req0_b, req0_op)});
            if (req1_valid && req1_ready)
                exp1.push_back('{cyc: cyc, res: fp_model(req1_a, req1_b, req1_op)});
            chk("rsp_both", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid) begin
                chk("rsp0_pending", {31'b0, exp0.size() > 0}, 32'd1);
                if (exp0.size() > 0) begin
                    exp_t e;
                    e = exp0.pop_front();
                    chk("rsp0_result", rsp0_result, e.res);
                    chk("rsp0_latency", cyc - e.cyc, LAT + 2);
                end
            end
            if (rsp1_valid) begin
                chk("rsp1_pending", {31'b0, exp1.size() > 0}, 32'd1);
                if (exp1.size() > 0) begin
                    exp_t e;
                    e = exp1.pop_front();
                    chk("rsp1_result", rsp1_result, e.res);
                    chk("rsp1_latency", cyc - e.cyc, LAT + 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        exp0.delete();
        exp1.delete();
        repeat (2) tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; en = 0; inject = 0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 0;
        do_reset();
        @(negedge clk);
        chk("reset_fu_valid", {31'b0, fu_valid}, 32'd0);
        chk("reset_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_err", {31'b0, err_mismatch}, 32'd0);
        chk("reset_fu_a", fu_a, 32'd0);

        // Single op on requester 0.
        tick();
        en = 1; req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 0;
        @(negedge clk);
        chk("t1_ready0", {31'b0, req0_ready}, 32'd1);
        chk("t1_ready1", {31'b0, req1_ready}, 32'd0);
        tick(); idle_inputs();
        @(negedge clk);
        chk("t1_fu_valid", {31'b0, fu_valid}, 32'd1);
        chk("t1_fu_a", fu_a, 32'h3F800000);
        chk("t1_fu_b", fu_b, 32'h40000000);
        repeat (3) tick();
        @(negedge clk);
        chk("t1_fu_res_valid", {31'b0, fu_res_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("t1_rsp0_result", rsp0_result, 32'h40400000);
        chk("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        repeat (3) tick();

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000; req0_op = 0;
            req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_op = 1;
            @(negedge clk);
            chk("t2_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) chk("t2_fu_op", {31'b0, fu_op}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
        end
        tick(); idle_inputs();
        @(negedge clk);
        chk("t2_fu_op_last", {31'b0, fu_op}, 32'd1);
        chk("t2_fu_a_last", fu_a, 32'h40400000);
        repeat (8) tick();

        // Requester 1 streaming alone.
        for (int i = 0; i < 6; i++) begin
            tick();
            req1_valid = 1; req1_a = 32'h41000000 + i; req1_b = 32'h3F000000 + 3 * i; req1_op = i[0];
            @(negedge clk);
            chk("t3_ready1", {31'b0, req1_ready}, 32'd1);
            if (i > 0) chk("t3_fu_valid", {31'b0, fu_valid}, 32'd1);
        end
        tick(); idle_inputs();
        @(negedge clk);
        chk("t3_fu_valid_last", {31'b0, fu_valid}, 32'd1);
        repeat (8) tick();

        // Grant enable gating and drain timing of busy.
        tick();
        en = 0; req0_valid = 1; req0_a = 32'h40800000; req0_b = 32'h3F800000; req0_op = 1;
        @(negedge clk);
        chk("t4_ready0_blocked", {31'b0, req0_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("t4_fu_valid_blocked", {31'b0, fu_valid}, 32'd0);
        chk("t4_ready0_blocked2", {31'b0, req0_ready}, 32'd0);
        tick();
        en = 1;
        @(negedge clk);
        chk("t4_ready0_en", {31'b0, req0_ready}, 32'd1);
        gcyc = cyc;
        tick();
        en = 0;
        @(negedge clk);
        chk("t4_fu_valid", {31'b0, fu_valid}, 32'd1);
        chk("t4_ready0_off", {31'b0, req0_ready}, 32'd0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            @(negedge clk);
            chk("t4_busy", {31'b0, busy}, (cyc - gcyc <= LAT + 2) ? 32'd1 : 32'd0);
        end
        tick(); idle_inputs(); en = 1;
        repeat (2) tick();

        // Protocol error: unit strobe with empty tail.
        tick();
        inject = 1;
        @(negedge clk);
        chk("t5_err_before", {31'b0, err_mismatch}, 32'd0);
        tick();
        inject = 0;
        @(negedge clk);
        chk("t5_err_set", {31'b0, err_mismatch}, 32'd1);
        chk("t5_no_rsp0", {31'b0, rsp0_valid}, 32'd0);
        chk("t5_no_rsp1", {31'b0, rsp1_valid}, 32'd0);
        tick();
        req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_op = 0;
        tick(); idle_inputs();
        repeat (7) tick();
        @(negedge clk);
        chk("t5_err_sticky", {31'b0, err_mismatch}, 32'd1);

        // Asynchronous reset with two ops in flight.
        tick();
        req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 0;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_op = 1;
        tick(); idle_inputs();
        rst_n = 0;
        exp0.delete();
        exp1.delete();
        #1;
        chk("t6_fu_valid", {31'b0, fu_valid}, 32'd0);
        chk("t6_fu_a", fu_a, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_err", {31'b0, err_mismatch}, 32'd0);
        chk("t6_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("t6_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        repeat (2) tick();
        rst_n = 1;
        repeat (8) tick();
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000; req0_op = 0;
        tick(); idle_inputs();
        repeat (7) tick();
        @(negedge clk);
        chk("end_exp0_empty", exp0.size(), 32'd0);
        chk("end_exp1_empty", exp1.size(), 32'd0);
        chk("end_err_clear", {31'b0, err_mismatch}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
